// File: rtl/priority_decoder_seq.sv
// Handshaked 2-bit code to 3-bit select pulse generator with programmable hold and idle gap.
// Optional macro PRIORITY_DECODER_THERMO_EN switches from one-hot to thermometer decode.
//
// state | meaning
// IDLE  | ready for a code; null codes counted here
// HOLD  | decoded select driven, counter running down
// GAP   | forced-zero output before returning to IDLE
module priority_decoder_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] code_i,
  input  logic       code_valid_i,
  output logic       code_ready_o,
  output logic [2:0] data_out_o,
  output logic       data_valid_o,
  output logic [7:0] null_cnt_o
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  // Parameters are limited to 8 bits; larger values are not supported.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       accept;

  function automatic logic [2:0] decode(input logic [1:0] c);
    logic [2:0] d;
    case (c)
`ifdef PRIORITY_DECODER_THERMO_EN
      2'b01:   d = 3'b001;
      2'b10:   d = 3'b011;
      2'b11:   d = 3'b111;
`else
      2'b01:   d = 3'b001;
      2'b10:   d = 3'b010;
      2'b11:   d = 3'b100;
`endif
      default: d = 3'b000;
    endcase
    return d;
  endfunction

  assign code_ready_o = (state == IDLE) && !rst_i;
  assign accept       = code_valid_i && code_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      data_out_o   <= 3'b000;
      data_valid_o <= 1'b0;
      null_cnt_o   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (code_i == 2'b00) begin
              if (null_cnt_o != 8'hFF) null_cnt_o <= null_cnt_o + 8'd1;
            end else begin
              data_out_o   <= decode(code_i);
              data_valid_o <= 1'b1;
              cnt          <= HOLD_LOAD;
              state        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            data_out_o   <= 3'b000;
            data_valid_o <= 1'b0;
            if (GAP_CYCLES > 0) begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) state <= IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed self-checking bench for priority_decoder_seq: default timing instance plus a
// HOLD=1/GAP=0 instance. Honours PRIORITY_DECODER_THERMO_EN for expected decode values.
module tb_priority_decoder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] code = 2'b00;
  logic       valid = 1'b0;
  logic       ready;
  logic [2:0] dout;
  logic       dvalid;
  logic [7:0] ncnt;

  logic [1:0] code2 = 2'b00;
  logic       valid2 = 1'b0;
  logic       ready2;
  logic [2:0] dout2;
  logic       dvalid2;
  logic [7:0] ncnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  priority_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk_i(clk), .rst_i(rst), .code_i(code), .code_valid_i(valid),
    .code_ready_o(ready), .data_out_o(dout), .data_valid_o(dvalid), .null_cnt_o(ncnt)
  );

  priority_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .code_i(code2), .code_valid_i(valid2),
    .code_ready_o(ready2), .data_out_o(dout2), .data_valid_o(dvalid2), .null_cnt_o(ncnt2)
  );

  function automatic logic [2:0] exp_dec(input logic [1:0] c);
`ifdef PRIORITY_DECODER_THERMO_EN
    if (c == 2'b11) return 3'b111;
    if (c == 2'b10) return 3'b011;
    if (c == 2'b01) return 3'b001;
`else
    if (c == 2'b11) return 3'b100;
    if (c == 2'b10) return 3'b010;
    if (c == 2'b01) return 3'b001;
`endif
    return 3'b000;
  endfunction

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (dout !== 3'b000) begin errors++; $display("FAIL reset_dout got %b want 000", dout); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dvalid); end
    checks++; if (ncnt !== 8'd0) begin errors++; $display("FAIL reset_null got %0d want 0", ncnt); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b want 0", ready); end
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", ready); end
  endtask

  task automatic test_single();
    int low_cnt;
    code = 2'b10; valid = 1'b1;
    tick();
    // a null code offered while busy must be ignored and not counted
    code = 2'b00;
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout !== exp_dec(2'b10)) begin errors++; $display("FAIL single_dout[%0d] got %b want %b", i, dout, exp_dec(2'b10)); end
      checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b want 1", i, dvalid); end
      if (!ready) low_cnt++;
      tick();
    end
    valid = 1'b0;
    checks++; if (dout !== 3'b000) begin errors++; $display("FAIL single_dout_end got %b want 000", dout); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL single_valid_end got %b want 0", dvalid); end
    if (!ready) low_cnt++;
    tick();
    checks++; if (low_cnt !== 5) begin errors++; $display("FAIL single_ready_low got %0d want 5", low_cnt); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_back got %b want 1", ready); end
    checks++; if (ncnt !== 8'd0) begin errors++; $display("FAIL single_null_ignored got %0d want 0", ncnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] q [3];
    int acc [3];
    int k;
    logic pend;
    q[0] = 2'b11; q[1] = 2'b01; q[2] = 2'b10;
    k = 0; pend = 1'b0;
    code = q[0]; valid = 1'b1;
    for (int c = 0; c < 100 && k < 3; c++) begin
      if (ready) begin acc[k] = cyc; pend = 1'b1; end
      tick();
      if (pend) begin
        checks++; if (dout !== exp_dec(q[k])) begin errors++; $display("FAIL b2b_dout[%0d] got %b want %b", k, dout, exp_dec(q[k])); end
        checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", k, dvalid); end
        k++;
        pend = 1'b0;
        if (k < 3) code = q[k];
        else valid = 1'b0;
      end
    end
    valid = 1'b0;
    checks++;
    if (k != 3) begin
      errors++; $display("FAIL b2b_timeout got %0d accepts want 3", k);
    end else begin
      checks++; if (acc[1] - acc[0] != 6) begin errors++; $display("FAIL b2b_spacing01 got %0d want 6", acc[1] - acc[0]); end
      checks++; if (acc[2] - acc[1] != 6) begin errors++; $display("FAIL b2b_spacing12 got %0d want 6", acc[2] - acc[1]); end
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_null();
    int expn;
    code = 2'b00; valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL null_ready[%0d] got %b want 1", i, ready); end
      tick();
      expn = (i + 1 > 255) ? 255 : i + 1;
      checks++; if (ncnt !== 8'(expn)) begin errors++; $display("FAIL null_cnt[%0d] got %0d want %0d", i, ncnt, expn); end
      checks++; if (dvalid !== 1'b0 || dout !== 3'b000) begin errors++; $display("FAIL null_out[%0d] got %b/%b want 0/000", i, dvalid, dout); end
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_gap0();
    logic [2:0] e;
    code2 = 2'b01; valid2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = (i % 2 == 0) ? exp_dec(2'b01) : 3'b000;
      checks++; if (dout2 !== e) begin errors++; $display("FAIL gap0_dout[%0d] got %b want %b", i, dout2, e); end
      checks++; if (dvalid2 !== (i % 2 == 0)) begin errors++; $display("FAIL gap0_valid[%0d] got %b want %b", i, dvalid2, (i % 2 == 0)); end
      checks++; if (ready2 !== (i % 2 == 1)) begin errors++; $display("FAIL gap0_ready[%0d] got %b want %b", i, ready2, (i % 2 == 1)); end
    end
    valid2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    code = 2'b11; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    checks++; if (dout !== exp_dec(2'b11)) begin errors++; $display("FAIL mid_pre_dout got %b want %b", dout, exp_dec(2'b11)); end
    rst = 1'b1;
    tick();
    checks++; if (dout !== 3'b000) begin errors++; $display("FAIL mid_dout got %b want 000", dout); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", dvalid); end
    checks++; if (ncnt !== 8'd0) begin errors++; $display("FAIL mid_null got %0d want 0", ncnt); end
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", ready); end
    code = 2'b01; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++; if (dout !== exp_dec(2'b01)) begin errors++; $display("FAIL mid_new_dout got %b want %b", dout, exp_dec(2'b01)); end
    checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %b want 1", dvalid); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (ready !== 1'b1 || dvalid !== 1'b0) begin errors++; $display("FAIL mid_drain got %b/%b want 1/0", ready, dvalid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_null();
    test_gap0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_decoder_seq.md
# priority_decoder_seq

Sequential 2-bit code decoder for the 3-input priority encoding: accepts one encoded index per valid/ready handshake and drives the matching 3-bit select line for a programmable number of cycles. A programmable idle gap follows each select pulse. It sits downstream of the priority encoder and regenerates per-channel select/enable pulses from the compressed code. Null codes (2'b00) are consumed without producing a pulse and are counted.

## Interface
- `HOLD_CYCLES`, default 4: cycles the decoded output is held active; legal range 1..255.
- `GAP_CYCLES`, default 1: cycles of forced-zero output after each hold, before the next code is accepted; legal range 0..255.
- `clk_i`  input  1  single clock; all logic on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `code_i`  input  2  encoded index; 2'b11 = channel 2, 2'b10 = channel 1, 2'b01 = channel 0, 2'b00 = none.
- `code_valid_i`  input  1  `code_i` is valid this cycle.
- `code_ready_o`  output  1  block can accept a code this cycle.
- `data_out_o`  output  3  decoded select, registered.
- `data_valid_o`  output  1  high while `data_out_o` holds a decoded pulse.
- `null_cnt_o`  output  8  saturating count of accepted 2'b00 codes.

## Operation
- Handshake: a code is accepted on a rising edge where `code_valid_i && code_ready_o`. `code_i` is sampled only on acceptance.
- `code_ready_o` = (state == IDLE) && !rst_i. It is combinational from the state register.
- FSM states are IDLE, HOLD and GAP.
  - IDLE, accept of a non-zero code: latch the decoded value into `data_out_o`, set `data_valid_o`, load counter = HOLD_CYCLES-1, go to HOLD.
  - IDLE, accept of 2'b00: increment `null_cnt_o`, which saturates at 255. Remain in IDLE; outputs unchanged (zero).
  - IDLE, no accept: remain in IDLE.
  - HOLD: if counter == 0, clear `data_out_o` and `data_valid_o`. Then go to GAP with counter = GAP_CYCLES-1 if GAP_CYCLES > 0, else go to IDLE. Otherwise decrement the counter.
  - GAP: if counter == 0, go to IDLE; else decrement. Outputs stay zero.
- Decode (default): 01 → 3'b001, 10 → 3'b010, 11 → 3'b100.
- Output invariants:
  - `data_out_o` is zero whenever `data_valid_o` is 0.
  - `data_out_o` is never changed mid-hold.
  - Codes presented while not ready are ignored and not counted.
- Counter width is 8 bits; parameters above 255 are illegal. No other arithmetic.

## Timing
- Reset: while `rst_i` is high at an edge, the following are cleared:
  - state → IDLE
  - `data_out_o` = 0, `data_valid_o` = 0, `null_cnt_o` = 0, counter = 0
  - `code_ready_o` = 0 while `rst_i` is high, 1 on the first cycle after release.
- Latency: code accepted at edge N → `data_out_o` and `data_valid_o` are valid from edge N (visible in cycle N+1) for exactly HOLD_CYCLES cycles.
- Ready is deasserted for HOLD_CYCLES+GAP_CYCLES cycles after a non-zero accept. Minimum accept-to-accept spacing is HOLD_CYCLES+GAP_CYCLES+1 edges.
- GAP_CYCLES = 0: `data_valid_o` goes low in the same edge that returns to IDLE. A new code can be accepted in the very next cycle, giving at least one zero-output cycle between pulses.
- Back-to-back null codes: one accepted per cycle; the counter increments every cycle and holds at 255.
- Reset mid-HOLD or mid-GAP: the pulse is truncated immediately at that edge. No residual gap; the block is ready in the first cycle after reset release.
- A `code_valid_i` with an X/changing `code_i` while not ready has no effect.

## Configuration
- `PRIORITY_DECODER_THERMO_EN`
  - Defined: thermometer decode. 01 → 3'b001, 10 → 3'b011, 11 → 3'b111. Priority-encoding the output returns the original code.
  - Undefined: one-hot decode as in Operation.
  - All timing, handshake and null-code behaviour are identical in both builds.

## Test plan
- Reset release, HOLD_CYCLES = 4, GAP_CYCLES = 1: present 2'b10 with valid for one cycle → `data_out_o` = 3'b010 and `data_valid_o` = 1 for 4 cycles, then 0. Ready is low for 5 cycles, then high.
- Hold `code_valid_i` high with 11, 01, 10 queued (source waits on ready) → pulses 3'b100, 3'b001, 3'b010 (thermo build: 111, 001, 011). Accepts are exactly 6 edges apart.
- 300 consecutive valid 2'b00 codes → `null_cnt_o` reaches 255 and holds; `data_valid_o` stays 0; ready stays high throughout.
- GAP_CYCLES = 0, HOLD_CYCLES = 1, continuous valid code 01 → output alternates 001/000 every cycle; accepts every 2 edges.
- Assert `rst_i` on the 2nd cycle of a hold → next edge: all outputs 0, `null_cnt_o` = 0. The first cycle after release has ready = 1, and a new code is accepted with normal latency.
